// File: rtl/gain_pkg.sv
// Shared constants, debounce state encoding and the saturating shift helper
// for the multi-channel gain ramp.
package gain_pkg;

   localparam int DEF_CH        = 2;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_GAIN_W    = 8;
   localparam int DEF_GAIN_FRAC = 6;

   typedef enum logic [1:0] {
      REL,
      PRESS_WAIT,
      PRESSED,
      REL_WAIT
   } deb_state_t;

   // Arithmetic shift right by frac, then clamp into a signed out_w-bit range.
   function automatic logic signed [63:0] sat_shift(input logic signed [63:0] product,
                                                    input int                 frac,
                                                    input int                 out_w);
      logic signed [63:0] shifted;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      shifted = product >>> frac;
      hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo      = -(64'sd1 <<< (out_w - 1));
      if (shifted > hi)
         sat_shift = hi;
      else if (shifted < lo)
         sat_shift = lo;
      else
         sat_shift = shifted;
   endfunction

endpackage

// File: rtl/multi_channel_gain_ramp_if.sv
// Sample-frame bus: packed multi-channel samples with a valid strobe in each
// direction. The gain stage is the slave, the sample source/sink the master.
interface multi_channel_gain_ramp_if
   import gain_pkg::*;
#(
   parameter int CH     = DEF_CH,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [CH*DATA_W-1:0] Data_in;
   logic                 in_valid;
   logic [CH*DATA_W-1:0] Data_out;
   logic                 out_valid;

   modport master (
      output Data_in,
      output in_valid,
      input  Data_out,
      input  out_valid
   );

   modport slave (
      input  Data_in,
      input  in_valid,
      output Data_out,
      output out_valid
   );

endinterface

// File: rtl/key_debounce.sv
// Active-low key synchroniser and debouncer. Emits exactly one single-cycle
// step pulse per accepted press; bounces on release never re-trigger.
module key_debounce
   import gain_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic key_n,
   output logic step
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [1:0]       sync_q;
   logic             key_low;
   deb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             step_d;

   // Two-flop synchroniser; idles at "released" (high).
   always_ff @(posedge Clk or negedge Reset_n) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
      if (!Reset_n)
         sync_q <= 2'b11;
      else
         sync_q <= {sync_q[0], key_n};
   end

   assign key_low = ~sync_q[1];

   // Debounce state, stability counter and registered step pulse.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= REL;
         cnt_q   <= '0;
         step    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step    <= step_d;
      end
   end

   // Next-state logic; the counter holds the number of consecutive stable cycles seen.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      step_d  = 1'b0;
      case (state_q)
         REL: begin
            if (key_low) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         PRESS_WAIT: begin
            if (!key_low) begin
               state_d = REL;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = PRESSED;
               step_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!key_low) begin
               state_d = REL_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         REL_WAIT: begin
            if (key_low)
               state_d = PRESSED;
            else if (cnt_q >= CNT_LAST)
               state_d = REL;
            else
               cnt_d = cnt_q + 1'b1;
         end
         default: state_d = REL;
      endcase
   end

endmodule

// File: rtl/multi_channel_gain_ramp.sv
// Shared button-controlled gain over CH channels with debounced volume keys,
// mute, per-sample gain ramping and a 2-stage saturating datapath.
// Optional feature: define GAIN_CLIP_DETECT_EN to add sticky per-channel
// clip flags (cleared by reset or a volume-down step).
module multi_channel_gain_ramp
   import gain_pkg::*;
#(
   parameter int CH           = DEF_CH,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int GAIN_W       = DEF_GAIN_W,
   parameter int GAIN_FRAC    = DEF_GAIN_FRAC,
   parameter int MAX_LEVEL    = 15,
   parameter int STEP         = 16,
   parameter int RESET_LEVEL  = 4,
   parameter int RAMP_STEP    = 1,
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic                             Clk,
   input  logic                             Reset_n,
   input  logic                             Vol_up,
   input  logic                             Vol_down,
   input  logic                             Mute,
   multi_channel_gain_ramp_if.slave         bus,
   output logic [$clog2(MAX_LEVEL+1)-1:0]   level,
`ifdef GAIN_CLIP_DETECT_EN
   output logic [CH-1:0]                    clip,
`endif
   output logic [GAIN_W-1:0]                gain_code
);

   localparam int LVL_W  = $clog2(MAX_LEVEL + 1);
   localparam int PROD_W = DATA_W + GAIN_W + 1;
   localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(MAX_LEVEL);
   localparam logic [LVL_W-1:0]  LVL_RST   = LVL_W'(RESET_LEVEL);
   localparam logic [GAIN_W-1:0] GAIN_RST  = GAIN_W'(RESET_LEVEL * STEP);
   localparam logic [GAIN_W-1:0] RAMP_G    = GAIN_W'(RAMP_STEP);

   logic              up_step, down_step;
   logic [GAIN_W-1:0] target, diff, delta, gain_d;
   logic              v1_q, out_valid_q;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_up (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .key_n   (Vol_up),
      .step    (up_step)
   );

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_down (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .key_n   (Vol_down),
      .step    (down_step)
   );

   // Volume level: saturating up/down; simultaneous steps cancel.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         level <= LVL_RST;
      else if (up_step && !down_step && level != LVL_MAX)
         level <= level + 1'b1;
      else if (down_step && !up_step && level != '0)
         level <= level - 1'b1;
   end

   // Target gain and the bounded ramp step taken on each accepted sample.
   always_comb begin
      target = Mute ? '0 : GAIN_W'(int'(level) * STEP);
      diff   = (target > gain_code) ? (target - gain_code) : (gain_code - target);
      delta  = (diff > RAMP_G) ? RAMP_G : diff;
      gain_d = gain_code;
      if (bus.in_valid)
         gain_d = (target > gain_code) ? (gain_code + delta) : (gain_code - delta);
   end

   // Applied gain; the sample in the same cycle still sees the old value.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         gain_code <= GAIN_RST;
      else
         gain_code <= gain_d;
   end

   // Valid pipeline; reset drops any samples in flight.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         v1_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         v1_q        <= bus.in_valid;
         out_valid_q <= v1_q;
      end
   end

   assign bus.out_valid = out_valid_q;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic signed [DATA_W-1:0] sample;
      logic signed [PROD_W-1:0] prod_q;
      logic signed [63:0]       sat_full;
      logic [DATA_W-1:0]        dout_q;

      assign sample = bus.Data_in[c*DATA_W +: DATA_W];

      // Stage 1: full-precision signed product with the unsigned gain.
      always_ff @(posedge Clk or negedge Reset_n) begin
         // NOTE: these pipeline registers are reset because the output must read 0 after reset.
         if (!Reset_n)
            prod_q <= '0;
         else if (bus.in_valid)
            prod_q <= PROD_W'(sample) * PROD_W'($signed({1'b0, gain_code}));
      end

      assign sat_full = sat_shift(64'(prod_q), GAIN_FRAC, DATA_W);

      // Stage 2: rescale and saturate; holds between valid samples.
      always_ff @(posedge Clk or negedge Reset_n) begin
         if (!Reset_n)
            dout_q <= '0;
         else if (v1_q)
            dout_q <= DATA_W'(sat_full);
      end

      assign bus.Data_out[c*DATA_W +: DATA_W] = dout_q;

`ifdef GAIN_CLIP_DETECT_EN
      logic clip_q;

      // Sticky clip flag: set when saturation changed the value, cleared by a down step.
      always_ff @(posedge Clk or negedge Reset_n) begin
         if (!Reset_n)
            clip_q <= 1'b0;
         else if (down_step)
            clip_q <= 1'b0;
         else if (v1_q && (sat_full != (64'(prod_q) >>> GAIN_FRAC)))
            clip_q <= 1'b1;
      end

      assign clip[c] = clip_q;
`endif
   end

endmodule

// File: doc/multi_channel_gain_ramp.md
Name: multi_channel_gain_ramp

Overview:
- Parametrised successor to the single-channel button-stepped gain stage.
- Sits between the audio interface ADC output and the pedal board input.
- Applies one shared, button-controlled gain to CH parallel channels, with debounced volume keys, mute, and per-sample gain ramping to avoid zipper noise.
- Output is saturated and passes through a 2-stage pipeline; the level is exported for the hex display.

Parameters:
- CH, 2, number of parallel audio channels.
- DATA_W, 16, signed sample width per channel.
- GAIN_W, 8, unsigned gain code width.
- GAIN_FRAC, 6, fractional bits of the gain code (64 = unity).
- MAX_LEVEL, 15, highest volume level.
- STEP, 16, gain code per level (target = level*STEP); MAX_LEVEL*STEP must be < 2^GAIN_W.
- RESET_LEVEL, 4, level after reset (unity gain).
- RAMP_STEP, 1, maximum change of the gain code per accepted sample.
- DEBOUNCE_CYC, 500000, number of stable cycles required to accept a key transition.

Ports:
- Clk, in, 1, system clock.
- Reset_n, in, 1, asynchronous active-low reset.
- Vol_up, in, 1, raw active-low key; increments level.
- Vol_down, in, 1, raw active-low key; decrements level.
- Mute, in, 1, level-sensitive; forces target gain to 0.
- Data_in, in, CH*DATA_W, channel c occupies bits [c*DATA_W +: DATA_W].
- in_valid, in, 1, one-cycle strobe per sample frame.
- Data_out, out, CH*DATA_W, gained and saturated samples, same packing as Data_in.
- out_valid, out, 1, strobe aligned with Data_out.
- level, out, $clog2(MAX_LEVEL+1), current volume level.
- gain_code, out, GAIN_W, gain currently applied.

Behaviour:
- Reset values:
  - level = RESET_LEVEL.
  - gain_code = RESET_LEVEL*STEP.
  - Data_out = 0, out_valid = 0.
  - Debouncers idle (key state "released").
  - Pipeline valids cleared.
- Key path, per key:
  - 2-flop synchroniser.
  - Debounce FSM with states REL, PRESS_WAIT, PRESSED, REL_WAIT.
  - REL -> PRESS_WAIT on sync low.
  - PRESS_WAIT -> PRESSED after DEBOUNCE_CYC consecutive low cycles; returns to REL on any high.
  - Entering PRESSED emits a 1-cycle step pulse.
  - PRESSED -> REL_WAIT on high.
  - REL_WAIT -> REL after DEBOUNCE_CYC consecutive high cycles; returns to PRESSED on any low (no new pulse).
  - Result: exactly one step per physical press.
- Level update:
  - Up pulse: level+1, saturating at MAX_LEVEL.
  - Down pulse: level-1, saturating at 0.
  - Both pulses in the same cycle: no change.
  - Level changes 1 cycle after the pulse.
- Target gain = Mute ? 0 : level*STEP. Level is retained while muted.
- Ramp:
  - On each cycle with in_valid=1, gain_code moves toward target by min(RAMP_STEP, |target-gain_code|).
  - The sample accepted in that cycle uses the pre-update gain_code.
  - No ramp movement without in_valid.
- Datapath, per channel:
  - Stage 1 registers product = signed(sample) * signed({1'b0, gain_code}), width DATA_W+GAIN_W+1.
  - Stage 2 registers sat(product >>> GAIN_FRAC) into [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Latency: in_valid at cycle t gives out_valid and Data_out at t+2.
  - Back-to-back in_valid is supported at full rate.
  - Data_out holds its value when out_valid=0.
- Reset mid-ramp or mid-pipeline: all state returns to reset values immediately; in-flight samples are discarded (no out_valid).

Optional Feature:
- Macro: GAIN_CLIP_DETECT_EN.
- When defined:
  - Adds output clip, width CH, one sticky flag per channel.
  - A flag sets when stage-2 saturation alters that channel's value.
  - Flags clear on reset or on a down-step pulse.
  - Flags reset to 0.
- When undefined: the port and logic are absent; saturation behaviour is unchanged.

Decomposition:
- Package gain_pkg:
  - Constants for the default widths.
  - Debounce state enum (REL, PRESS_WAIT, PRESSED, REL_WAIT).
  - Function sat_shift(product, frac, out_w).
- Sub-module key_debounce (sync + FSM + counter + step pulse), instantiated twice.
- Top contains the level counter, ramp, and generate-loop datapath over CH.

Test Plan (DEBOUNCE_CYC=4 in bench):
- Reset, then ch0=0x1000 and ch1=0xF000 with in_valid -> 2 cycles later out_valid=1, ch0=0x1000, ch1=0xF000; level=4, gain_code=64.
- Vol_up low for 6 cycles then high for 6 -> level=5, target 80; 16 in_valid strobes ramp gain_code 64->80 in steps of 1; next sample 0x1000 -> 0x1400.
- Vol_up glitch low for 3 cycles -> level unchanged at 4; Vol_up held low for 100 cycles -> exactly one step.
- Level stepped to 15 (gain 240), inputs 0x7000 / 0x8000 -> outputs 0x7FFF / 0x8000; with GAIN_CLIP_DETECT_EN, clip=2'b11. Extra up press -> level stays 15.
- Mute=1 at level 4 -> gain_code ramps 64->0 over 64 samples, output 0; Mute=0 -> ramps back to 64; level=4 throughout.
- Reset_n pulsed low during a ramp with samples in flight -> next cycle: gain_code=64, level=4, out_valid=0, Data_out=0.
